// File: rtl/fpu_unpack_pkg.sv
// Shared FPU types for the unpack stage: rounding modes, the unpacked operand layout
// consumed by the rounding stage, and a 24-bit leading-zero counter.
package fpu_unpack_pkg;

    localparam int FPU_EXP_MAX      = 255;
    localparam int FPU_UNPACK_EXP_W = 10;

    typedef enum logic [2:0] {
        FPU_RNE = 3'd0,
        FPU_RTZ = 3'd1,
        FPU_RDN = 3'd2,
        FPU_RUP = 3'd3,
        FPU_RMM = 3'd4
    } fpu_round_mode_t;

    typedef struct packed {
        logic                        sign;
        logic [FPU_UNPACK_EXP_W-1:0] exponent;
        logic [23:0]                 mantissa;
        logic [2:0]                  guard;
        fpu_round_mode_t             mode;
        logic                        nan;
        logic                        snan;
        logic                        inf;
        logic                        zero;
        logic                        subnormal;
    } fpu_unpacked_t;

    typedef enum logic {
        UNPACK_IDLE = 1'b0,
        UNPACK_NORM = 1'b1
    } unpack_state_e;

    // Returns 24 for an all-zero input.
    function automatic logic [4:0] fpu_lzc24(input logic [23:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd0;
        found = 1'b0;
        for (int i = 23; i >= 0; i--) begin
            if (v[i]) begin
                found = 1'b1;
            end else if (!found) begin
                n = n + 5'd1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/fpu_unpack_if.sv
// Operand-in / unpacked-result-out handshake bundle of the FPU front end.
interface fpu_unpack_if;
    import fpu_unpack_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_data;
    fpu_round_mode_t in_mode;
    logic            out_valid;
    logic            out_ready;
    logic            out_sign;
    logic [9:0]      out_exponent;
    logic [23:0]     out_mantissa;
    logic [2:0]      out_guard;
    fpu_round_mode_t out_mode;
    logic            out_nan;
    logic            out_snan;
    logic            out_inf;
    logic            out_zero;
    logic            out_subnormal;

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_sign, out_exponent, out_mantissa, out_guard,
               out_mode, out_nan, out_snan, out_inf, out_zero, out_subnormal
    );

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_sign, out_exponent, out_mantissa, out_guard,
               out_mode, out_nan, out_snan, out_inf, out_zero, out_subnormal
    );

endinterface

// File: rtl/fpu_unpack_classify.sv
// Combinational split of a packed single into unpacked fields plus class flags.
// Subnormals come out un-normalized: mantissa {0,F}, exponent 1.
module fpu_unpack_classify
    import fpu_unpack_pkg::*;
(
    input  logic [31:0]     data_i,
    input  fpu_round_mode_t mode_i,
    output fpu_unpacked_t   fields_o
);

    logic [7:0]  exp_f;
    logic [22:0] frac_f;

    assign exp_f  = data_i[30:23];
    assign frac_f = data_i[22:0];

    always_comb begin
        // NOTE: full default first so every path assigns every field -- no latches.
        fields_o      = '0;
        fields_o.sign = data_i[31];
        fields_o.mode = mode_i;
        if (exp_f == 8'(FPU_EXP_MAX)) begin
            fields_o.exponent = 10'(FPU_EXP_MAX);
            fields_o.mantissa = {1'b1, frac_f};
            if (frac_f != 23'd0) begin
                fields_o.nan  = 1'b1;
                fields_o.snan = !frac_f[22];
            end else begin
                fields_o.inf  = 1'b1;
            end
        end else if (exp_f == 8'd0) begin
            if (frac_f == 23'd0) begin
                fields_o.zero      = 1'b1;
            end else begin
                fields_o.subnormal = 1'b1;
                fields_o.exponent  = 10'd1;
                fields_o.mantissa  = {1'b0, frac_f};
            end
        end else begin
            fields_o.exponent = {2'b00, exp_f};
            fields_o.mantissa = {1'b1, frac_f};
        end
    end

endmodule

// File: rtl/fpu_unpack.sv
// Pipelined single-precision unpacker: one normal/special per cycle, subnormals
// left-normalized by an iterative shifter that stalls the input side.
module fpu_unpack
    import fpu_unpack_pkg::*;
#(
    parameter int SHIFT_STEP = 4
) (
    input logic          clk,
    input logic          rst,
    fpu_unpack_if.slave  bus
);

    localparam logic [4:0] STEP_MAX = 5'(SHIFT_STEP);

    unpack_state_e state_q, state_d;
    fpu_unpacked_t work_q, work_d;
    fpu_unpacked_t out_q, out_d;
    logic          out_valid_q, out_valid_d;

    fpu_unpacked_t cls;
    fpu_unpacked_t norm_res;
    logic [4:0]    lz;
    logic [4:0]    step_amt;
    logic          out_free;
    logic          accept;

    fpu_unpack_classify u_classify (
        .data_i   (bus.in_data),
        .mode_i   (bus.in_mode),
        .fields_o (cls)
    );

    assign out_free     = !out_valid_q || bus.out_ready;
    assign bus.in_ready = (state_q == UNPACK_IDLE) && out_free;
    assign accept       = bus.in_valid && bus.in_ready;

    // Exponent starts at 1 and drops by each shift, giving 1 - (total shift).
    assign lz       = fpu_lzc24(work_q.mantissa);
    assign step_amt = (lz > STEP_MAX) ? STEP_MAX : lz;

    always_comb begin
        norm_res          = work_q;
        norm_res.mantissa = work_q.mantissa << step_amt;
        norm_res.exponent = work_q.exponent - {5'd0, step_amt};
    end

    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
        case (state_q)
            UNPACK_IDLE: begin
                if (accept) begin
                    if (cls.subnormal) begin
                        work_d  = cls;
                        state_d = UNPACK_NORM;
                    end else begin
                        out_d       = cls;
                        out_valid_d = 1'b1;
                    end
                end
            end
            UNPACK_NORM: begin
                if (!norm_res.mantissa[23]) begin
                    work_d = norm_res;
                end else if (out_free) begin
                    out_d       = norm_res;
                    out_valid_d = 1'b1;
                    state_d     = UNPACK_IDLE;
                end
            end
            default: state_d = UNPACK_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst) begin
            state_q     <= UNPACK_IDLE;
            work_q      <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.out_valid     = out_valid_q;
    assign bus.out_sign      = out_q.sign;
    assign bus.out_exponent  = out_q.exponent;
    assign bus.out_mantissa  = out_q.mantissa;
    assign bus.out_guard     = out_q.guard;
    assign bus.out_mode      = out_q.mode;
    assign bus.out_nan       = out_q.nan;
    assign bus.out_snan      = out_q.snan;
    assign bus.out_inf       = out_q.inf;
    assign bus.out_zero      = out_q.zero;
    assign bus.out_subnormal = out_q.subnormal;

endmodule

// File: tb/tb_fpu_unpack.sv
// Self-checking bench for fpu_unpack: directed class/latency cases, stall and reset
// behaviour, then randomized traffic against an arithmetic reference model.
module tb_fpu_unpack;
    import fpu_unpack_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fpu_unpack_if bus4 ();
    fpu_unpack_if bus1 ();

    fpu_unpack #(.SHIFT_STEP(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
    fpu_unpack #(.SHIFT_STEP(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    int n_checks = 0;
    int n_errors = 0;
    fpu_unpacked_t exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Value-based model: a subnormal F*2^-149 with top set bit p becomes 1.x * 2^(p-149),
    // i.e. biased exponent p-22, mantissa F scaled so bit p lands on bit 23.
    function automatic fpu_unpacked_t ref_unpack(input logic [31:0] d, input fpu_round_mode_t m);
        fpu_unpacked_t r;
        int e, f, p;
        r      = '0;
        r.sign = d[31];
        r.mode = m;
        e      = int'(d[30:23]);
        f      = int'(d[22:0]);
        if (e == 255) begin
            r.exponent = 10'd255;
            r.mantissa = 24'(f + 32'h800000);
            if (f != 0) begin
                r.nan  = 1'b1;
                r.snan = (f < 32'h400000);
            end else begin
                r.inf  = 1'b1;
            end
        end else if (e == 0 && f == 0) begin
            r.zero = 1'b1;
        end else if (e == 0) begin
            p = 22;
            while (((f >> p) & 1) == 0) p--;
            r.subnormal = 1'b1;
            r.exponent  = 10'(p - 22);
            r.mantissa  = 24'(f * (1 << (23 - p)));
        end else begin
            r.exponent = 10'(e);
            r.mantissa = 24'(f + 32'h800000);
        end
        return r;
    endfunction

    function automatic int ref_norm_cycles(input logic [31:0] d, input int step);
        int f, p;
        f = int'(d[22:0]);
        if (d[30:23] != 8'd0 || f == 0) return 0;
        p = 22;
        while (((f >> p) & 1) == 0) p--;
        return (23 - p + step - 1) / step;
    endfunction

    function automatic fpu_unpacked_t sample4();
        fpu_unpacked_t r;
        r.sign      = bus4.out_sign;
        r.exponent  = bus4.out_exponent;
        r.mantissa  = bus4.out_mantissa;
        r.guard     = bus4.out_guard;
        r.mode      = bus4.out_mode;
        r.nan       = bus4.out_nan;
        r.snan      = bus4.out_snan;
        r.inf       = bus4.out_inf;
        r.zero      = bus4.out_zero;
        r.subnormal = bus4.out_subnormal;
        return r;
    endfunction

    task automatic check_result(input string tag, input fpu_unpacked_t got, input fpu_unpacked_t exp);
        check({tag, ".sign"},     32'(got.sign),     32'(exp.sign));
        check({tag, ".exponent"}, 32'(got.exponent), 32'(exp.exponent));
        check({tag, ".mantissa"}, 32'(got.mantissa), 32'(exp.mantissa));
        check({tag, ".guard"},    32'(got.guard),    32'(exp.guard));
        check({tag, ".mode"},     32'(got.mode),     32'(exp.mode));
        check({tag, ".flags"},
              32'({got.nan, got.snan, got.inf, got.zero, got.subnormal}),
              32'({exp.nan, exp.snan, exp.inf, exp.zero, exp.subnormal}));
    endtask

    // Starts and ends on a falling edge with out_ready held high.
    task automatic run4(input string tag, input logic [31:0] d, input fpu_round_mode_t m);
        int   cnt;
        logic busy_ready;
        int   exp_cycles;
        exp_cycles     = ref_norm_cycles(d, 4);
        bus4.in_valid  = 1'b1;
        bus4.in_data   = d;
        bus4.in_mode   = m;
        bus4.out_ready = 1'b1;
        #1;
        check({tag, ".in_ready"}, 32'(bus4.in_ready), 32'd1);
        @(negedge clk);
        bus4.in_valid = 1'b0;
        cnt        = 0;
        busy_ready = 1'b0;
        while (!bus4.out_valid && cnt < 100) begin
            busy_ready |= bus4.in_ready;
            cnt++;
            @(negedge clk);
        end
        check({tag, ".latency"}, 32'(cnt), 32'(exp_cycles));
        if (exp_cycles > 0) check({tag, ".stall"}, 32'(busy_ready), 32'd0);
        check_result(tag, sample4(), ref_unpack(d, m));
        @(negedge clk);
        check({tag, ".drained"}, 32'(bus4.out_valid), 32'd0);
    endtask

    function automatic logic [31:0] rand_operand();
        logic [22:0] f;
        logic        s;
        s = 1'($urandom);
        f = 23'($urandom);
        case ($urandom % 8)
            0: begin
                f = f >> $urandom_range(0, 22);
                if (f == 23'd0) f = 23'd1;
                return {s, 8'd0, f};
            end
            1: return {s, 8'd0, 23'd0};
            2: return {s, 8'hFF, 23'd0};
            3: return {s, 8'hFF, (f == 23'd0) ? 23'd1 : f};
            default: return {s, 8'($urandom_range(1, 254)), f};
        endcase
    endfunction

    task automatic score_cycle();
        fpu_unpacked_t e;
        if (bus4.in_valid && bus4.in_ready) exp_q.push_back(ref_unpack(bus4.in_data, bus4.in_mode));
        if (bus4.out_valid && bus4.out_ready) begin
            if (exp_q.size() == 0) begin
                check("rand.spurious_out", 32'(bus4.out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_result("rand", sample4(), e);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors);
        $fatal(1);
    end

    logic [31:0] dir_data [8] = '{32'h3F800000, 32'h00000001, 32'h00400000, 32'h7FC00000,
                                  32'h7F800001, 32'hFF800000, 32'h80000000, 32'hC0490FDB};

    initial begin
        int   cnt;
        logic seen;
        bus4.in_valid = 1'b0; bus4.in_data = '0; bus4.in_mode = FPU_RNE; bus4.out_ready = 1'b1;
        bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.in_mode = FPU_RNE; bus1.out_ready = 1'b1;

        repeat (3) @(negedge clk);
        check("reset.out_valid", 32'(bus4.out_valid), 32'd0);
        check("reset.fields", 32'(sample4() != '0), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("reset.in_ready", 32'(bus4.in_ready), 32'd1);

        foreach (dir_data[i]) run4($sformatf("dir%0d", i), dir_data[i], fpu_round_mode_t'(3'(i % 5)));

        // Single-bit shifter: 0x00000001 needs 23 NORM cycles.
        bus1.in_valid = 1'b1;
        bus1.in_data  = 32'h00000001;
        @(negedge clk);
        bus1.in_valid = 1'b0;
        cnt  = 0;
        seen = 1'b0;
        while (!bus1.out_valid && cnt < 100) begin
            seen |= bus1.in_ready;
            cnt++;
            @(negedge clk);
        end
        check("step1.latency", 32'(cnt), 32'd23);
        check("step1.stall", 32'(seen), 32'd0);
        check("step1.exponent", 32'(bus1.out_exponent), 32'h3EA);
        check("step1.mantissa", 32'(bus1.out_mantissa), 32'h800000);
        check("step1.subnormal", 32'(bus1.out_subnormal), 32'd1);
        @(negedge clk);

        // Back-to-back with the consumer stalled for three cycles.
        bus4.out_ready = 1'b0;
        bus4.in_valid  = 1'b1;
        bus4.in_data   = 32'h40000000;
        bus4.in_mode   = FPU_RTZ;
        @(negedge clk);
        bus4.in_data = 32'h40400000;
        bus4.in_mode = FPU_RUP;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("b2b.hold%0d.valid", i), 32'(bus4.out_valid), 32'd1);
            check($sformatf("b2b.hold%0d.in_ready", i), 32'(bus4.in_ready), 32'd0);
            check_result($sformatf("b2b.hold%0d", i), sample4(), ref_unpack(32'h40000000, FPU_RTZ));
            @(negedge clk);
        end
        bus4.out_ready = 1'b1;
        #1;
        check("b2b.drain_in_ready", 32'(bus4.in_ready), 32'd1);
        @(negedge clk);
        bus4.in_valid = 1'b0;
        check("b2b.second_valid", 32'(bus4.out_valid), 32'd1);
        check_result("b2b.second", sample4(), ref_unpack(32'h40400000, FPU_RUP));
        @(negedge clk);
        check("b2b.empty", 32'(bus4.out_valid), 32'd0);

        // Reset while the shifter is busy.
        bus4.in_valid = 1'b1;
        bus4.in_data  = 32'h00000001;
        @(negedge clk);
        bus4.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst.out_valid", 32'(bus4.out_valid), 32'd0);
        check("midrst.idle", 32'(bus4.in_ready), 32'd1);
        rst  = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            seen |= bus4.out_valid;
        end
        check("midrst.quiet", 32'(seen), 32'd0);
        run4("post_rst", 32'h3F800000, FPU_RMM);

        // Randomized traffic with random back-pressure.
        repeat (600) begin
            bus4.out_ready = ($urandom % 4) != 0;
            bus4.in_valid  = ($urandom % 3) != 0;
            bus4.in_data   = rand_operand();
            bus4.in_mode   = fpu_round_mode_t'(3'($urandom_range(0, 4)));
            #1;
            score_cycle();
            @(negedge clk);
        end
        bus4.in_valid  = 1'b0;
        bus4.out_ready = 1'b1;
        cnt = 0;
        while (exp_q.size() != 0 && cnt < 200) begin
            #1;
            score_cycle();
            cnt++;
            @(negedge clk);
        end
        check("rand.drain_left", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
